// File: rtl/writeback_stage.sv
// Final pipeline stage: merges buffered ALU results and extended load data
// into the register file write port, with loads taking priority.
module writeback_stage #(
   parameter int REG_WIDTH  = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alu_valid,
   output logic                          alu_ready,
   input  logic [ADDR_WIDTH-1:0]         alu_rd,
   input  logic [REG_WIDTH-1:0]          alu_result,
   input  logic                          ld_valid,
   input  logic [ADDR_WIDTH-1:0]         ld_rd,
   input  logic [2:0]                    ld_funct3,
   input  logic [1:0]                    ld_byte_off,
   input  logic [REG_WIDTH-1:0]          ld_word,
   output logic [ADDR_WIDTH-1:0]         wrAddr,
   output logic [REG_WIDTH-1:0]          wrData,
   output logic                          wrEna,
   output logic                          ld_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] q_rd   [FIFO_DEPTH];
   logic [REG_WIDTH-1:0]  q_data [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  push;
   logic                  pop;

   assign alu_ready  = count != FULL;
   assign fifo_count = count;
   assign push       = alu_valid && alu_ready;
   assign pop        = !ld_valid && count != '0;

   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= alu_rd;
         q_data[wr_ptr] <= alu_result;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   logic [REG_WIDTH-1:0] byte_sh;
   logic [REG_WIDTH-1:0] half_sh;
   logic [7:0]           byte_v;
   logic [15:0]          half_v;
   logic [REG_WIDTH-1:0] ld_data;
   logic                 ld_bad;

   always_comb begin
      byte_sh = ld_word >> {ld_byte_off, 3'b000};
      half_sh = ld_word >> {ld_byte_off[1], 4'b0000};
      byte_v  = byte_sh[7:0];
      half_v  = half_sh[15:0];
      ld_data = '0;
      ld_bad  = 1'b0;
      case (ld_funct3)
         3'b000: ld_data = {{(REG_WIDTH-8){byte_v[7]}}, byte_v};
         3'b100: ld_data = {{(REG_WIDTH-8){1'b0}}, byte_v};
         3'b001: begin
            ld_bad  = ld_byte_off[0];
            ld_data = {{(REG_WIDTH-16){half_v[15]}}, half_v};
         end
         3'b101: begin
            ld_bad  = ld_byte_off[0];
            ld_data = {{(REG_WIDTH-16){1'b0}}, half_v};
         end
         3'b010: begin
            ld_bad  = ld_byte_off != 2'b00;
            ld_data = ld_word;
         end
         default: ld_bad = 1'b1;
      endcase
   end

   // x0 targets and faulting loads are consumed without touching addr/data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrEna  <= 1'b0;
         wrAddr <= '0;
         wrData <= '0;
         ld_err <= 1'b0;
      end else begin
         unique case (1'b1)
            ld_valid: begin
               ld_err <= ld_bad;
               wrEna  <= !ld_bad && ld_rd != '0;
               if (!ld_bad && ld_rd != '0) begin
                  wrAddr <= ld_rd;
                  wrData <= ld_data;
               end
            end
            pop: begin
               ld_err <= 1'b0;
               wrEna  <= q_rd[rd_ptr] != '0;
               if (q_rd[rd_ptr] != '0) begin
                  wrAddr <= q_rd[rd_ptr];
                  wrData <= q_data[rd_ptr];
               end
            end
            default: begin
               ld_err <= 1'b0;
               wrEna  <= 1'b0;
            end
         endcase
      end
   end

endmodule
